// File: rtl/uvmt_apb_st_slv_mem_if.sv
// APB bus bundle between the self-test master and the memory completer.
// The master modport drives the request side; the slave modport returns the response.
interface uvmt_apb_st_slv_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/uvmt_apb_st_slv_mem.sv
// APB completer holding DEPTH word registers, with configurable wait states,
// pslverr on misaligned or out-of-range accesses, and a completed-transfer counter.
module uvmt_apb_st_slv_mem #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    uvmt_apb_st_slv_mem_if.slave    apb,
    output logic [15:0]             xfer_cnt
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  lat_wr, lat_wr_nxt;
    logic                  lat_legal, lat_legal_nxt;
    logic [IDX_W-1:0]      lat_idx, lat_idx_nxt;
    logic [DATA_WIDTH-1:0] lat_wdata, lat_wdata_nxt;
    logic                  pready_q, pready_nxt;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_nxt;
    logic                  pslverr_q, pslverr_nxt;
    logic [15:0]           xfer_cnt_nxt;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address decode of the live bus, used when the setup phase is sampled.
    logic [ADDR_WIDTH-1:0] dec_word;
    logic                  dec_legal;
    logic [IDX_W-1:0]      dec_idx;

    always_comb begin
        dec_word  = apb.paddr >> 2;
        dec_legal = (apb.paddr[1:0] == 2'b00) && (dec_word < ADDR_WIDTH'(DEPTH));
        dec_idx   = IDX_W'(dec_word);
    end

    // Response source: live decode on a zero-wait setup, latched values otherwise.
    logic             go_ready;
    logic             sel_wr;
    logic             sel_legal;
    logic [IDX_W-1:0] sel_idx;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lat_wr_nxt    = lat_wr;
        lat_legal_nxt = lat_legal;
        lat_idx_nxt   = lat_idx;
        lat_wdata_nxt = lat_wdata;
        pready_nxt    = 1'b0;
        prdata_nxt    = '0;
        pslverr_nxt   = 1'b0;
        xfer_cnt_nxt  = xfer_cnt;
        mem_we        = 1'b0;
        go_ready      = 1'b0;
        sel_wr        = lat_wr;
        sel_legal     = lat_legal;
        sel_idx       = lat_idx;

        case (state)
            S_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    lat_wr_nxt    = apb.pwrite;
                    lat_legal_nxt = dec_legal;
                    lat_idx_nxt   = dec_idx;
                    lat_wdata_nxt = apb.pwdata;
                    if (WAIT_STATES == 0) begin
                        go_ready  = 1'b1;
                        sel_wr    = apb.pwrite;
                        sel_legal = dec_legal;
                        sel_idx   = dec_idx;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                if (!apb.psel) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (apb.penable) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        go_ready = 1'b1;
                    end
                end
            end
            S_READY: begin
                state_nxt = S_IDLE;
                if (apb.psel) begin
                    mem_we       = lat_wr && lat_legal;
                    xfer_cnt_nxt = xfer_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (go_ready) begin
            state_nxt   = S_READY;
            pready_nxt  = 1'b1;
            pslverr_nxt = !sel_legal;
            if (sel_legal && !sel_wr) begin
                prdata_nxt = mem[sel_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_wr    <= 1'b0;
            lat_legal <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            xfer_cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_wr    <= lat_wr_nxt;
            lat_legal <= lat_legal_nxt;
            lat_idx   <= lat_idx_nxt;
            lat_wdata <= lat_wdata_nxt;
            pready_q  <= pready_nxt;
            prdata_q  <= prdata_nxt;
            pslverr_q <= pslverr_nxt;
            xfer_cnt  <= xfer_cnt_nxt;
            if (mem_we) begin
                mem[lat_idx] <= lat_wdata;
            end
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
endmodule

// File: tb/tb_uvmt_apb_st_slv_mem.sv
// Self-checking bench for uvmt_apb_st_slv_mem: a zero-wait and a three-wait instance
// driven by directed vectors, hand sequences and random transfers against a word-array model.
module tb_uvmt_apb_st_slv_mem;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uvmt_apb_st_slv_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    uvmt_apb_st_slv_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();
    logic [15:0] cnt0, cnt3;

    uvmt_apb_st_slv_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .apb(bus0.slave), .xfer_cnt(cnt0));
    uvmt_apb_st_slv_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset), .apb(bus3.slave), .xfer_cnt(cnt3));

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one word array and transfer counter per instance.
    logic [31:0] ref_mem [2][DEPTH];
    logic [15:0] ref_cnt [2];
    int          ws [2] = '{0, 3};

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;
    vec_t vt [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic sel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] w);
        if (d == 0) begin
            bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = w;
            bus3.psel = 1'b0; bus3.penable = 1'b0;
        end else begin
            bus3.psel = sel; bus3.penable = en; bus3.pwrite = wr; bus3.paddr = a; bus3.pwdata = w;
            bus0.psel = 1'b0; bus0.penable = 1'b0;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.pready : bus3.pready;
    endfunction
    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? bus0.prdata : bus3.prdata;
    endfunction
    function automatic logic serr(input int d);
        return (d == 0) ? bus0.pslverr : bus3.pslverr;
    endfunction
    function automatic logic [15:0] xcnt(input int d);
        return (d == 0) ? cnt0 : cnt3;
    endfunction

    function automatic bit is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < DEPTH);
    endfunction

    task automatic model_apply(input int d, input bit wr, input logic [31:0] a, input logic [31:0] w);
        if (wr && is_legal(a)) ref_mem[d][int'(a >> 2)] = w;
        ref_cnt[d] = ref_cnt[d] + 16'd1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ref_cnt[d] = 16'd0;
            for (int i = 0; i < DEPTH; i++) ref_mem[d][i] = 32'h0;
        end
    endtask

    // One complete transfer; paddr/pwdata are scrambled during the access phase.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] w,
                        output logic [31:0] rd, output bit err, output int lat);
        @(negedge clk);
        drive(d, 1'b1, 1'b0, wr, a, w);
        @(negedge clk);
        drive(d, 1'b1, 1'b1, wr, $urandom, $urandom);
        lat = 1;
        while (!rdy(d) && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        rd  = rdat(d);
        err = serr(d);
    endtask

    task automatic check_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] rd;
        logic [31:0] exp_rd;
        bit          err;
        int          lat;
        exp_rd = 32'h0;
        if (is_legal(a) && !wr) exp_rd = ref_mem[d][int'(a >> 2)];
        xfer(d, wr, a, w, rd, err, lat);
        chk("latency", 32'(lat), 32'(ws[d] + 1));
        chk("pslverr", 32'(err), 32'(!is_legal(a)));
        chk("prdata", rd, exp_rd);
        model_apply(d, wr, a, w);
    endtask

    task automatic go_idle(input int d);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("pready_single_cycle", 32'(rdy(d)), 32'h0);
        chk("xfer_cnt", 32'(xcnt(d)), 32'(ref_cnt[d]));
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        bit          err;
        int          lat;
        int unsigned c0;
        int          d;
        bit          wr;

        vt[0] = '{1'b1, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0};
        vt[1] = '{1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b1, 32'h06, 32'h1234,     32'h0,        1'b1};
        vt[3] = '{1'b0, 32'h40, 32'h0,        32'h0,        1'b1};
        vt[4] = '{1'b0, 32'h04, 32'h0,        32'h0,        1'b0};
        vt[5] = '{1'b1, 32'h3C, 32'hCAFEF00D, 32'h0,        1'b0};
        vt[6] = '{1'b0, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0};
        vt[7] = '{1'b0, 32'h3E, 32'h0,        32'h0,        1'b1};
        vt[8] = '{1'b1, 32'h44, 32'h5555,     32'h0,        1'b1};

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pready0", 32'(bus0.pready), 32'h0);
        chk("rst_prdata0", bus0.prdata, 32'h0);
        chk("rst_pslverr0", 32'(bus0.pslverr), 32'h0);
        chk("rst_cnt0", 32'(cnt0), 32'h0);
        chk("rst_pready3", 32'(bus3.pready), 32'h0);
        chk("rst_cnt3", 32'(cnt3), 32'h0);
        reset = 1'b0;

        // Three-wait read right after reset: pready at T0+4 for one cycle.
        xfer(1, 1'b0, 32'h00, 32'h0, rd, err, lat);
        chk("ws3_latency", 32'(lat), 32'd4);
        chk("ws3_prdata", rd, 32'h0);
        chk("ws3_pslverr", 32'(err), 32'h0);
        model_apply(1, 1'b0, 32'h00, 32'h0);
        go_idle(1);

        // Directed vectors on the zero-wait instance, back to back.
        for (int i = 0; i < 9; i++) begin
            xfer(0, vt[i].wr, vt[i].addr, vt[i].wdata, rd, err, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            chk($sformatf("vec%0d_prdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vt[i].exp_err));
            model_apply(0, vt[i].wr, vt[i].addr, vt[i].wdata);
            if (i == 1) begin
                @(negedge clk);
                chk("cnt_after_wr_rd", 32'(cnt0), 32'd2);
                drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        go_idle(0);
        chk("vec_cnt", 32'(cnt0), 32'd9);

        // psel dropped during the wait states of a write.
        check_xfer(1, 1'b1, 32'h0C, 32'h11112222);
        go_idle(1);
        @(negedge clk); drive(1, 1'b1, 1'b0, 1'b1, 32'h0C, 32'hA5A5A5A5);
        @(negedge clk); drive(1, 1'b1, 1'b1, 1'b1, 32'h0C, 32'hA5A5A5A5);
        chk("abort_wait_pready_a", 32'(bus3.pready), 32'h0);
        @(negedge clk);
        chk("abort_wait_pready_b", 32'(bus3.pready), 32'h0);
        @(negedge clk); drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("abort_wait_pready_c", 32'(bus3.pready), 32'h0);
        go_idle(1);
        check_xfer(1, 1'b0, 32'h0C, 32'h0);
        go_idle(1);

        // psel dropped in the completing cycle of a zero-wait write.
        @(negedge clk); drive(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h00000055);
        @(negedge clk); drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        go_idle(0);
        check_xfer(0, 1'b0, 32'h10, 32'h0);
        go_idle(0);

        // Back-to-back reads take two cycles each.
        c0 = cyc;
        for (int i = 0; i < 200; i++) begin
            a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            check_xfer(0, 1'b0, a, 32'h0);
        end
        chk("b2b_cycles", cyc - c0, 32'd400);
        go_idle(0);

        // Random mixed traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                7:       a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                8, 9:    a = $urandom | 32'h40;
                default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            check_xfer(d, wr, a, $urandom);
            if ($urandom_range(0, 3) == 0) go_idle(d);
        end
        go_idle(0);
        go_idle(1);

        // Fill every word, then reset in the completing cycle of a write.
        for (int i = 0; i < DEPTH; i++) check_xfer(0, 1'b1, 32'(i) << 2, $urandom | 32'h1);
        @(negedge clk); drive(0, 1'b1, 1'b0, 1'b1, 32'h00, 32'hFFFF0000);
        @(negedge clk); drive(0, 1'b1, 1'b1, 1'b1, 32'h00, 32'hFFFF0000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_reset();
        chk("midrst_pready", 32'(bus0.pready), 32'h0);
        chk("midrst_prdata", bus0.prdata, 32'h0);
        chk("midrst_pslverr", 32'(bus0.pslverr), 32'h0);
        chk("midrst_cnt", 32'(cnt0), 32'h0);
        for (int i = 0; i < DEPTH; i++) check_xfer(0, 1'b0, 32'(i) << 2, 32'h0);
        go_idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uvmt_apb_st_slv_mem.md
# uvmt_apb_st_slv_mem

Synthesizable APB completer (slave) for the APB self-test bench: the responding end of the bus that the agent's master drives. Holds a bank of DEPTH word registers, answers reads and writes with a parameterized number of wait states, flags misaligned and out-of-range accesses with pslverr, and counts completed transfers. It replaces a pure passthrough as the DUT when the master agent is run against real RTL instead of the slave agent.

## Interface
- ADDR_WIDTH, 32: paddr width.
- DATA_WIDTH, 32: pwdata/prdata width; memory word width.
- DEPTH, 16: number of word registers; word index range 0..DEPTH-1.
- WAIT_STATES, 0: extra access-phase cycles before pready; range 0..15.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data, valid only with pready on a read.
- pslverr  out  1  error response, valid only with pready.
- xfer_cnt  out  16  count of completed transfers (ok or error).

## Operation
- Decode: idx = paddr >> 2; access is legal iff paddr[1:0] == 0 and idx < DEPTH. Illegal → error.
- FSM states IDLE, WAIT, READY. Registered outputs; pready/prdata/pslverr are 0 in IDLE and WAIT.
- IDLE: on psel=1, penable=0 (setup) latch pwrite, idx, legal flag, pwdata. If WAIT_STATES=0 go READY, else go WAIT with cnt = WAIT_STATES. Without setup stay IDLE.
- WAIT: while psel=1, penable=1: cnt decrements; on the cycle cnt reaches 1 go READY. Access phase therefore lasts WAIT_STATES+1 cycles, pready high on the last.
- On entry to READY: pready<=1; pslverr<=~legal; prdata<=mem[idx] for a legal read, else 0.
- READY: legal write commits mem[idx]<=pwdata at the end of this cycle; error write leaves memory unchanged. xfer_cnt increments (wraps 0xFFFF→0). Next state IDLE, outputs cleared.
- Abort: psel=0 in WAIT or READY → IDLE next cycle, no write, no count, outputs cleared.
- penable=1 observed in IDLE (no setup) is ignored.
- Reset: FSM→IDLE, cnt=0, all mem words=0, xfer_cnt=0, pready=prdata=pslverr=0. Reset mid-transfer drops the transfer with no write.

## Timing
- Setup cycle T0; with WAIT_STATES=N pready is high in cycle T0+N+1, for exactly one cycle.
- Back-to-back: new setup in the cycle after READY is accepted (IDLE decodes it) — no dead cycle beyond the APB-mandated setup.
- Read-after-write to same address in the next transfer returns the new data.
- prdata/pslverr sampled from latched setup values; changes on paddr/pwdata during access phase have no effect.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x08, read 0x08 → pready in cycle after setup, prdata=0xDEADBEEF, pslverr=0, xfer_cnt=2.
- WAIT_STATES=3: read 0x00 after reset → pready high exactly at T0+4 for one cycle, prdata=0x0.
- Misaligned 0x06 write of 0x1234 then out-of-range 0x40 (DEPTH=16) read → both pslverr=1, prdata=0; re-read 0x04 unchanged.
- psel dropped in WAIT during write of 0xA5A5A5A5 to 0x0C → no pready, mem[3] unchanged, xfer_cnt unchanged.
- reset asserted mid-access after writing all 16 words → all outputs 0 next cycle, subsequent reads of 0x00..0x3C return 0.
- 65536 back-to-back reads → xfer_cnt wraps to 0, one transfer per 2 cycles with WAIT_STATES=0.
